// File: rtl/abs_cmd_ctrl_pkg.sv
// abs_cmd_ctrl_pkg: DMI addresses, command field positions, error codes and FSM states.
package abs_cmd_ctrl_pkg;
  localparam logic [6:0] ADDR_DATA0   = 7'h04;
  localparam logic [6:0] ADDR_ABSCS   = 7'h16;
  localparam logic [6:0] ADDR_COMMAND = 7'h17;
  localparam int CMDTYPE_HI  = 31;
  localparam int CMDTYPE_LO  = 24;
  localparam int AARSIZE_HI  = 22;
  localparam int AARSIZE_LO  = 20;
  localparam int TRANSFER_BIT = 17;
  localparam int WRITE_BIT    = 16;
  localparam int CMDERR_HI   = 10;
  localparam int CMDERR_LO   = 8;
  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_BUSY   = 3'd1,
    ERR_NOTSUP = 3'd2,
    ERR_EXC    = 3'd3,
    ERR_HALT   = 3'd4
  } cmderr_e;
  typedef enum logic {ST_IDLE, ST_BUSY} state_e;
  // datacount=1, progbufsize=0, everything else reserved as zero
  function automatic logic [31:0] abstractcs_word(input logic [2:0] err, input logic busy);
    return {19'd0, busy, 1'b0, err, 4'd0, 4'd1};
  endfunction
endpackage

// File: rtl/abs_cmd_ctrl_timer.sv
// abs_cmd_ctrl_timer: BUSY-phase cycle counter flagging when the timeout limit is reached.
module abs_cmd_ctrl_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
  assign expired_o = cnt_q == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/abs_cmd_ctrl.sv
// abs_cmd_ctrl: owns data0/command/abstractcs and sequences one abstract command at a time.
module abs_cmd_ctrl
  import abs_cmd_ctrl_pkg::*;
#(
  parameter int DM_REG_WIDTH   = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    dmi_wr,
  input  logic                    dmi_rd,
  input  logic [6:0]              dmi_addr,
  input  logic [DM_REG_WIDTH-1:0] dmi_wdata,
  output logic [DM_REG_WIDTH-1:0] dmi_rdata,
  output logic                    dmi_rvalid,
  input  logic                    halted,
  output logic [DM_REG_WIDTH-1:0] data0,
  output logic [DM_REG_WIDTH-1:0] command,
  output logic                    cmd_update,
  input  logic                    cmd_finished,
  input  logic [DATA_WIDTH-1:0]   cmd_read_data
);
  state_e                  state_q, state_d;
  logic [DM_REG_WIDTH-1:0] data0_q, data0_d, command_q, command_d, rdata_q, rdata_d;
  logic [2:0]              cmderr_q, cmderr_d;
  logic                    rvalid_q, timer_clr, expired, raise;
  cmderr_e                 err_code;
  logic                    wr_data0, wr_cmd, wr_abscs, busy, unsupported;
  assign busy      = state_q == ST_BUSY;
  assign wr_data0  = dmi_wr && dmi_addr == ADDR_DATA0;
  assign wr_cmd    = dmi_wr && dmi_addr == ADDR_COMMAND;
  assign wr_abscs  = dmi_wr && dmi_addr == ADDR_ABSCS;
  assign unsupported = dmi_wdata[CMDTYPE_HI:CMDTYPE_LO] != '0 ||
                       (dmi_wdata[TRANSFER_BIT] && dmi_wdata[AARSIZE_HI:AARSIZE_LO] != 3'd2);
  abs_cmd_ctrl_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .clr_i     (timer_clr),
    .en_i      (busy && !cmd_finished),
    .expired_o (expired)
  );
  always_comb begin
    state_d   = state_q;
    data0_d   = data0_q;
    command_d = command_q;
    cmderr_d  = wr_abscs ? cmderr_q & ~dmi_wdata[CMDERR_HI:CMDERR_LO] : cmderr_q;
    timer_clr = 1'b0;
    raise     = 1'b0;
    err_code  = ERR_NONE;
    if (!busy) begin
      if (wr_data0) data0_d = dmi_wdata;
      if (wr_cmd && cmderr_q == ERR_NONE) begin
        command_d = dmi_wdata;
        if (unsupported) begin
          raise    = 1'b1;
          err_code = ERR_NOTSUP;
        end else if (dmi_wdata[TRANSFER_BIT] && !halted) begin
          raise    = 1'b1;
          err_code = ERR_HALT;
        end else if (dmi_wdata[TRANSFER_BIT]) begin
          state_d   = ST_BUSY;
          timer_clr = 1'b1;
        end
      end
    end else begin
      if (wr_data0 || wr_cmd) begin
        raise    = 1'b1;
        err_code = ERR_BUSY;
      end
      // finish beats a same-cycle timeout and any DMI write to data0
      if (cmd_finished) begin
        data0_d = command_q[WRITE_BIT] ? data0_q : cmd_read_data;
        state_d = ST_IDLE;
      end else if (expired) begin
        raise    = 1'b1;
        err_code = ERR_EXC;
        state_d  = ST_IDLE;
      end
    end
    if (raise && cmderr_q == ERR_NONE) cmderr_d = err_code;
  end
  assign rdata_d = !dmi_rd ? rdata_q :
                   dmi_addr == ADDR_DATA0   ? data0_q :
                   dmi_addr == ADDR_COMMAND ? command_q :
                   dmi_addr == ADDR_ABSCS   ? DM_REG_WIDTH'(abstractcs_word(cmderr_q, busy)) : '0;
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      data0_q   <= '0;
      command_q <= '0;
      cmderr_q  <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      data0_q   <= data0_d;
      command_q <= command_d;
      cmderr_q  <= cmderr_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= dmi_rd;
    end
  assign dmi_rdata  = rdata_q;
  assign dmi_rvalid = rvalid_q;
  assign data0      = data0_q;
  assign command    = command_q;
  assign cmd_update = busy;
endmodule

// File: tb/tb_abs_cmd_ctrl.sv
// tb_abs_cmd_ctrl: scenario tasks plus a read-data scoreboard for abs_cmd_ctrl.
module tb_abs_cmd_ctrl;
  logic        sys_clk = 1'b0, sys_rst = 1'b1;
  logic        dmi_wr = 1'b0, dmi_rd = 1'b0;
  logic [6:0]  dmi_addr = '0;
  logic [31:0] dmi_wdata = '0, dmi_rdata, data0, command, cmd_read_data = '0;
  logic        dmi_rvalid, halted = 1'b1, cmd_update, cmd_finished = 1'b0;
  int          tests = 0, failed = 0;
  logic [31:0] exp_q[$];

  abs_cmd_ctrl dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .dmi_wr(dmi_wr), .dmi_rd(dmi_rd),
    .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata), .dmi_rdata(dmi_rdata),
    .dmi_rvalid(dmi_rvalid), .halted(halted), .data0(data0), .command(command),
    .cmd_update(cmd_update), .cmd_finished(cmd_finished), .cmd_read_data(cmd_read_data)
  );

  always #5 sys_clk = ~sys_clk;

  // read scoreboard: expectations queued when dmi_rd is issued
  always @(negedge sys_clk) if (dmi_rvalid) begin
    tests++;
    if (exp_q.size() == 0) begin
      failed++;
      $display("FAIL rd_unexpected: got rvalid with %08h, want no read outstanding", dmi_rdata);
    end else begin
      logic [31:0] e;
      e = exp_q.pop_front();
      if (dmi_rdata !== e) begin
        failed++;
        $display("FAIL rd_data: got %08h want %08h", dmi_rdata, e);
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic dmi_write(input logic [6:0] a, input logic [31:0] d);
    dmi_wr = 1'b1; dmi_addr = a; dmi_wdata = d;
    tick();
    dmi_wr = 1'b0;
  endtask

  task automatic dmi_read(input logic [6:0] a, input logic [31:0] e);
    dmi_rd = 1'b1; dmi_addr = a; exp_q.push_back(e);
    tick();
    dmi_rd = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    tick(); tick();
    tests++;
    if ({cmd_update, dmi_rvalid} !== 2'b00 || data0 !== 32'h0 || command !== 32'h0 || dmi_rdata !== 32'h0) begin
      failed++;
      $display("FAIL reset_outputs: got upd=%b rv=%b d0=%08h cmd=%08h rd=%08h want all 0",
               cmd_update, dmi_rvalid, data0, command, dmi_rdata);
    end
    sys_rst = 1'b0;
    tick();
    dmi_read(7'h16, 32'h0000_0001);
    dmi_read(7'h10, 32'h0);
  endtask

  task automatic test_reg_read();
    halted = 1'b1;
    dmi_write(7'h17, 32'h0022_1000);
    tests++;
    if (cmd_update !== 1'b1 || command !== 32'h0022_1000) begin
      failed++;
      $display("FAIL read_start: got upd=%b cmd=%08h want 1 00221000", cmd_update, command);
    end
    tick(); tick();
    cmd_finished = 1'b1; cmd_read_data = 32'hDEAD_BEEF;
    tick();
    cmd_finished = 1'b0;
    tests++;
    if (data0 !== 32'hDEAD_BEEF || cmd_update !== 1'b0) begin
      failed++;
      $display("FAIL read_capture: got d0=%08h upd=%b want deadbeef 0", data0, cmd_update);
    end
    dmi_read(7'h16, 32'h0000_0001);
    dmi_read(7'h04, 32'hDEAD_BEEF);
    dmi_read(7'h17, 32'h0022_1000);
  endtask

  task automatic test_reg_write();
    dmi_write(7'h04, 32'h1234_5678);
    dmi_write(7'h17, 32'h0023_0300);
    cmd_finished = 1'b1; cmd_read_data = 32'hFFFF_0000;
    tests++;
    if (cmd_update !== 1'b1) begin
      failed++;
      $display("FAIL write_update: got %b want 1", cmd_update);
    end
    tick();
    cmd_finished = 1'b0;
    tests++;
    if (cmd_update !== 1'b0 || data0 !== 32'h1234_5678) begin
      failed++;
      $display("FAIL write_done: got upd=%b d0=%08h want 0 12345678", cmd_update, data0);
    end
    dmi_read(7'h16, 32'h0000_0001);
  endtask

  task automatic test_unsupported();
    logic seen = 1'b0;
    dmi_write(7'h17, 32'h0100_0000);
    for (int i = 0; i < 4; i++) begin seen |= cmd_update; tick(); end
    dmi_read(7'h16, 32'h0000_0201);
    dmi_write(7'h17, 32'h0022_1000);
    seen |= cmd_update;
    tick();
    tests++;
    if (seen !== 1'b0 || command !== 32'h0100_0000) begin
      failed++;
      $display("FAIL unsup_ignored: got seen=%b cmd=%08h want 0 01000000", seen, command);
    end
    dmi_write(7'h16, 32'h0000_0700);
    dmi_read(7'h16, 32'h0000_0001);
    dmi_write(7'h17, 32'h0032_1000);
    tests++;
    if (cmd_update !== 1'b0) begin
      failed++;
      $display("FAIL aarsize_unsup: got upd=%b want 0", cmd_update);
    end
    dmi_read(7'h16, 32'h0000_0201);
    dmi_write(7'h16, 32'h0000_0700);
    dmi_write(7'h17, 32'h0020_0000);
    tests++;
    if (cmd_update !== 1'b0 || command !== 32'h0020_0000) begin
      failed++;
      $display("FAIL no_transfer: got upd=%b cmd=%08h want 0 00200000", cmd_update, command);
    end
    dmi_read(7'h16, 32'h0000_0001);
  endtask

  task automatic test_not_halted();
    halted = 1'b0;
    dmi_write(7'h17, 32'h0022_1000);
    tests++;
    if (cmd_update !== 1'b0) begin
      failed++;
      $display("FAIL not_halted_upd: got %b want 0", cmd_update);
    end
    dmi_read(7'h16, 32'h0000_0401);
    dmi_write(7'h16, 32'h0000_0700);
    halted = 1'b1;
  endtask

  task automatic test_busy_error();
    int cyc;
    dmi_write(7'h17, 32'h0022_1000);
    dmi_write(7'h04, 32'h5555_5555);
    dmi_read(7'h16, 32'h0000_1101);
    cyc = 2;
    while (cmd_update && cyc < 200) begin tick(); cyc++; end
    tests++;
    if (cyc !== 64) begin
      failed++;
      $display("FAIL timeout_cycles: got %0d want 64", cyc);
    end
    tests++;
    if (data0 !== 32'h1234_5678) begin
      failed++;
      $display("FAIL busy_data0: got %08h want 12345678", data0);
    end
    dmi_read(7'h16, 32'h0000_0101);
    dmi_write(7'h16, 32'h0000_0700);
  endtask

  task automatic test_timeout_boundary();
    dmi_write(7'h17, 32'h0022_1000);
    for (int i = 0; i < 63; i++) tick();
    tests++;
    if (cmd_update !== 1'b1) begin
      failed++;
      $display("FAIL boundary_busy: got %b want 1", cmd_update);
    end
    cmd_finished = 1'b1; cmd_read_data = 32'h0BAD_F00D;
    tick();
    cmd_finished = 1'b0;
    tests++;
    if (data0 !== 32'h0BAD_F00D || cmd_update !== 1'b0) begin
      failed++;
      $display("FAIL boundary_finish: got d0=%08h upd=%b want 0badf00d 0", data0, cmd_update);
    end
    dmi_read(7'h16, 32'h0000_0001);
  endtask

  task automatic test_back_to_back();
    dmi_write(7'h17, 32'h0022_1000);
    cmd_finished = 1'b1; cmd_read_data = 32'hCAFE_F00D;
    dmi_write(7'h04, 32'h5555_5555);
    cmd_finished = 1'b0;
    tests++;
    if (data0 !== 32'hCAFE_F00D) begin
      failed++;
      $display("FAIL capture_wins: got %08h want cafef00d", data0);
    end
    dmi_read(7'h16, 32'h0000_0101);
    dmi_write(7'h16, 32'h0000_0100);
    dmi_read(7'h16, 32'h0000_0001);
    dmi_wr = 1'b1; dmi_rd = 1'b1; dmi_addr = 7'h04; dmi_wdata = 32'hAAAA_0001;
    exp_q.push_back(32'hCAFE_F00D);
    tick();
    dmi_wr = 1'b0; dmi_rd = 1'b0;
    tests++;
    if (data0 !== 32'hAAAA_0001) begin
      failed++;
      $display("FAIL rw_same_cycle: got %08h want aaaa0001", data0);
    end
  endtask

  task automatic test_reset_mid();
    dmi_write(7'h17, 32'h0022_1000);
    tick();
    sys_rst = 1'b1;
    #1;
    tests++;
    if (cmd_update !== 1'b0) begin
      failed++;
      $display("FAIL async_reset_upd: got %b want 0", cmd_update);
    end
    tick();
    tests++;
    if (data0 !== 32'h0 || command !== 32'h0 || dmi_rdata !== 32'h0 || dmi_rvalid !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_outputs: got d0=%08h cmd=%08h rd=%08h rv=%b want 0",
               data0, command, dmi_rdata, dmi_rvalid);
    end
    sys_rst = 1'b0;
    tick();
    dmi_read(7'h16, 32'h0000_0001);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_reg_read();
    test_reg_write();
    test_unsupported();
    test_not_halted();
    test_busy_error();
    test_timeout_boundary();
    test_back_to_back();
    test_reset_mid();
    tick(); tick();
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL rd_outstanding: got %0d reads pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
